// File: rtl/alu_req_arbiter.sv
// Round-robin arbiter sharing one ALU between two requesters; latches the winner's
// operation, drives the ALU for the command's latency and returns result and flags.
// Build option: ALU_ARB_FIXED_PRIO_EN selects fixed priority (req0 over req1).
module alu_req_arbiter #(
    parameter int N_WIDTH  = 8,
    parameter int M_WIDTH  = 4,
    parameter int LAT_NORM = 1,
    parameter int LAT_MUL  = 2
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               req0_valid,
    output logic               req0_ready,
    input  logic               req0_mode,
    input  logic [M_WIDTH-1:0] req0_cmd,
    input  logic [N_WIDTH-1:0] req0_opa,
    input  logic [N_WIDTH-1:0] req0_opb,
    input  logic               req0_cin,
    input  logic               req1_valid,
    output logic               req1_ready,
    input  logic               req1_mode,
    input  logic [M_WIDTH-1:0] req1_cmd,
    input  logic [N_WIDTH-1:0] req1_opa,
    input  logic [N_WIDTH-1:0] req1_opb,
    input  logic               req1_cin,
    output logic               rsp0_valid,
    output logic               rsp1_valid,
    output logic [N_WIDTH+1:0] rsp_res,
    output logic [5:0]         rsp_flags,
    output logic               alu_ce,
    output logic [1:0]         alu_inp_valid,
    output logic               alu_mode,
    output logic [M_WIDTH-1:0] alu_cmd,
    output logic [N_WIDTH-1:0] alu_opa,
    output logic [N_WIDTH-1:0] alu_opb,
    output logic               alu_cin,
    input  logic [N_WIDTH+1:0] alu_res,
    input  logic               alu_err,
    input  logic               alu_oflow,
    input  logic               alu_cout,
    input  logic               alu_g,
    input  logic               alu_l,
    input  logic               alu_e
);

    localparam int LatMax = (LAT_MUL > LAT_NORM) ? LAT_MUL : LAT_NORM;
    localparam int CntW   = $clog2(LatMax + 1);

    typedef enum logic [1:0] {StIdle, StIssue, StWait, StCapture} state_t;

    state_t              state_q, state_d;
    logic [CntW-1:0]     cnt_q, cnt_d;
    logic [CntW-1:0]     lat_sel;
    logic                grant;
    logic                gnt_q;
    logic                handshake;
    logic                is_mul;
    logic                mode_q;
    logic [M_WIDTH-1:0]  cmd_q;
    logic [N_WIDTH-1:0]  opa_q;
    logic [N_WIDTH-1:0]  opb_q;
    logic                cin_q;
    logic                rsp0_q;
    logic                rsp1_q;
    logic [N_WIDTH+1:0]  rsp_res_q;
    logic [5:0]          rsp_flags_q;

`ifndef ALU_ARB_FIXED_PRIO_EN
    logic                last_grant_q;
`endif

    // grant is only meaningful when at least one requester is valid
    always_comb begin
        grant = 1'b0;
`ifdef ALU_ARB_FIXED_PRIO_EN
        grant = ~req0_valid;
`else
        if (req0_valid && req1_valid) begin
            grant = ~last_grant_q;
        end else begin
            grant = ~req0_valid;
        end
`endif
    end

    assign req0_ready = ~reset & (state_q == StIdle) & req0_valid & ~grant;
    assign req1_ready = ~reset & (state_q == StIdle) & req1_valid & grant;
    assign handshake  = req0_ready | req1_ready;

    assign is_mul  = mode_q && ((cmd_q == M_WIDTH'(9)) || (cmd_q == M_WIDTH'(10)));
    assign lat_sel = is_mul ? CntW'(LAT_MUL) : CntW'(LAT_NORM);

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        unique case (state_q)
            StIdle: begin
                if (handshake) begin
                    state_d = StIssue;
                end
            end
            StIssue: begin
                cnt_d   = lat_sel;
                state_d = (lat_sel > CntW'(1)) ? StWait : StCapture;
            end
            StWait: begin
                cnt_d = cnt_q - CntW'(1);
                if (cnt_d == CntW'(1)) begin
                    state_d = StCapture;
                end
            end
            StCapture: state_d = StIdle;
            default:   state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q     <= StIdle;
            cnt_q       <= '0;
            gnt_q       <= 1'b0;
            mode_q      <= 1'b0;
            cmd_q       <= '0;
            opa_q       <= '0;
            opb_q       <= '0;
            cin_q       <= 1'b0;
            rsp0_q      <= 1'b0;
            rsp1_q      <= 1'b0;
            rsp_res_q   <= '0;
            rsp_flags_q <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            rsp0_q  <= (state_q == StCapture) && !gnt_q;
            rsp1_q  <= (state_q == StCapture) && gnt_q;
            if (handshake) begin
                gnt_q  <= grant;
                mode_q <= grant ? req1_mode : req0_mode;
                cmd_q  <= grant ? req1_cmd  : req0_cmd;
                opa_q  <= grant ? req1_opa  : req0_opa;
                opb_q  <= grant ? req1_opb  : req0_opb;
                cin_q  <= grant ? req1_cin  : req0_cin;
            end
            if (state_q == StCapture) begin
                rsp_res_q   <= alu_res;
                rsp_flags_q <= {alu_err, alu_oflow, alu_cout, alu_g, alu_l, alu_e};
            end
        end
    end

`ifndef ALU_ARB_FIXED_PRIO_EN
    // reset value 1 lets req0 win the first contended grant
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            last_grant_q <= 1'b1;
        end else if (handshake) begin
            last_grant_q <= grant;
        end
    end
`endif

    assign alu_ce        = (state_q != StIdle);
    assign alu_inp_valid = alu_ce ? 2'b11 : 2'b00;
    assign alu_mode      = mode_q;
    assign alu_cmd       = cmd_q;
    assign alu_opa       = opa_q;
    assign alu_opb       = opb_q;
    assign alu_cin       = cin_q;
    assign rsp0_valid    = rsp0_q;
    assign rsp1_valid    = rsp1_q;
    assign rsp_res       = rsp_res_q;
    assign rsp_flags     = rsp_flags_q;

endmodule

// File: tb/tb_alu_req_arbiter.sv
// Self-checking bench for alu_req_arbiter: behavioural pipelined ALU model plus a
// scoreboard of expected responses filled on each accepted request.
module tb_alu_req_arbiter;

    localparam int NW = 8;
    localparam int MW = 4;
    localparam int LN = 1;
    localparam int LM = 2;

    logic          clk = 1'b0;
    logic          reset = 1'b1;
    logic          req0_valid = 1'b0, req0_mode = 1'b0, req0_cin = 1'b0;
    logic [MW-1:0] req0_cmd = '0;
    logic [NW-1:0] req0_opa = '0, req0_opb = '0;
    logic          req1_valid = 1'b0, req1_mode = 1'b0, req1_cin = 1'b0;
    logic [MW-1:0] req1_cmd = '0;
    logic [NW-1:0] req1_opa = '0, req1_opb = '0;
    logic          req0_ready, req1_ready, rsp0_valid, rsp1_valid;
    logic [NW+1:0] rsp_res;
    logic [5:0]    rsp_flags;
    logic          alu_ce, alu_mode, alu_cin;
    logic [1:0]    alu_inp_valid;
    logic [MW-1:0] alu_cmd;
    logic [NW-1:0] alu_opa, alu_opb;
    logic [NW+1:0] alu_res;
    logic          alu_err, alu_oflow, alu_cout, alu_g, alu_l, alu_e;

    alu_req_arbiter #(.N_WIDTH(NW), .M_WIDTH(MW), .LAT_NORM(LN), .LAT_MUL(LM)) dut (
        .clk(clk), .reset(reset),
        .req0_valid(req0_valid), .req0_ready(req0_ready), .req0_mode(req0_mode),
        .req0_cmd(req0_cmd), .req0_opa(req0_opa), .req0_opb(req0_opb), .req0_cin(req0_cin),
        .req1_valid(req1_valid), .req1_ready(req1_ready), .req1_mode(req1_mode),
        .req1_cmd(req1_cmd), .req1_opa(req1_opa), .req1_opb(req1_opb), .req1_cin(req1_cin),
        .rsp0_valid(rsp0_valid), .rsp1_valid(rsp1_valid), .rsp_res(rsp_res),
        .rsp_flags(rsp_flags), .alu_ce(alu_ce), .alu_inp_valid(alu_inp_valid),
        .alu_mode(alu_mode), .alu_cmd(alu_cmd), .alu_opa(alu_opa), .alu_opb(alu_opb),
        .alu_cin(alu_cin), .alu_res(alu_res), .alu_err(alu_err), .alu_oflow(alu_oflow),
        .alu_cout(alu_cout), .alu_g(alu_g), .alu_l(alu_l), .alu_e(alu_e)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    int checks = 0;
    int errors = 0;
    int both_ready_cnt = 0;

    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {
        int          ch;
        logic [9:0]  res;
        logic [5:0]  flags;
        int          due;
    } exp_t;

    exp_t exp_q[$];

    // returns {err,oflow,cout,g,l,e,res[9:0]}
    function automatic logic [15:0] alu_fn(input logic m, input logic [3:0] c,
                                           input logic [7:0] a, input logic [7:0] b,
                                           input logic ci);
        logic [9:0] r;
        logic       err;
        r   = '0;
        err = 1'b0;
        if (m) begin
            case (c)
                4'd0:    r = {2'b0, a} + {2'b0, b};
                4'd1:    r = {2'b0, a} - {2'b0, b};
                4'd2:    r = {2'b0, a} + {2'b0, b} + {9'b0, ci};
                4'd9:    r = ({2'b0, a} + 10'd1) * ({2'b0, b} + 10'd1);
                4'd10:   r = {1'b0, a, 1'b0} * {2'b0, b};
                default: err = 1'b1;
            endcase
        end else begin
            case (c)
                4'd0:    r = {2'b0, a & b};
                4'd1:    r = {2'b0, a | b};
                4'd2:    r = {2'b0, a ^ b};
                default: err = 1'b1;
            endcase
        end
        return {err, 1'b0, r[8], a > b, a < b, a == b, r};
    endfunction

    function automatic int lat_fn(input logic m, input logic [3:0] c);
        return (m && (c == 4'd9 || c == 4'd10)) ? LM : LN;
    endfunction

    // ALU model: stage1 one cycle after an enabled edge, stage2 for multiplies
    logic [15:0] s1 = '0, s2 = '0;
    always @(posedge clk) begin
        if (alu_ce) begin
            s1 <= alu_fn(alu_mode, alu_cmd, alu_opa, alu_opb, alu_cin);
            s2 <= s1;
        end
    end
    assign {alu_err, alu_oflow, alu_cout, alu_g, alu_l, alu_e, alu_res} =
        (alu_mode && (alu_cmd == 4'd9 || alu_cmd == 4'd10)) ? s2 : s1;

    logic [15:0] f0, f1;
    always @(posedge clk) begin
        if (!reset) begin
            if (req0_ready && req1_ready) both_ready_cnt <= both_ready_cnt + 1;
            if (req0_valid && req0_ready) begin
                f0 = alu_fn(req0_mode, req0_cmd, req0_opa, req0_opb, req0_cin);
                exp_q.push_back('{0, f0[9:0], f0[15:10], cyc + 2 + lat_fn(req0_mode, req0_cmd)});
            end
            if (req1_valid && req1_ready) begin
                f1 = alu_fn(req1_mode, req1_cmd, req1_opa, req1_opb, req1_cin);
                exp_q.push_back('{1, f1[9:0], f1[15:10], cyc + 2 + lat_fn(req1_mode, req1_cmd)});
            end
        end
    end

    task automatic drive(input int ch, input logic m, input logic [3:0] c,
                         input logic [7:0] a, input logic [7:0] b, input logic ci);
        if (ch == 0) begin
            req0_valid = 1'b1; req0_mode = m; req0_cmd = c;
            req0_opa = a; req0_opb = b; req0_cin = ci;
        end else begin
            req1_valid = 1'b1; req1_mode = m; req1_cmd = c;
            req1_opa = a; req1_opb = b; req1_cin = ci;
        end
    endtask

    task automatic rand_op(input int ch, output int lat);
        logic       m;
        logic [3:0] c;
        case ($urandom_range(0, 4))
            0:       begin m = 1'b1; c = 4'd0; end
            1:       begin m = 1'b1; c = 4'd1; end
            2:       begin m = 1'b1; c = 4'd9; end
            3:       begin m = 1'b0; c = 4'd1; end
            default: begin m = 1'b0; c = 4'd2; end
        endcase
        drive(ch, m, c, 8'($urandom_range(0, 255)), 8'($urandom_range(0, 15)), 1'($urandom));
        lat = lat_fn(m, c);
    endtask

    // ch: -1 timeout, 0/1 channel, 2 both pulsed
    task automatic wait_rsp(input int budget, output int ch);
        ch = -1;
        for (int i = 0; i < budget; i++) begin
            @(negedge clk);
            if (rsp0_valid || rsp1_valid) begin
                ch = rsp1_valid ? (rsp0_valid ? 2 : 1) : 0;
                return;
            end
        end
    endtask

    task automatic pop_exp(output exp_t e);
        if (exp_q.size() > 0) e = exp_q.pop_front();
        else e = '{-1, 10'h0, 6'h0, -1};
    endtask

    task automatic test_reset();
        @(negedge clk);
        @(negedge clk);
        checks++;
        if ({req0_ready, req1_ready, rsp0_valid, rsp1_valid, alu_ce, alu_inp_valid, alu_mode,
             alu_cmd, alu_opa, alu_opb, alu_cin, rsp_res, rsp_flags} !== '0) begin
            errors++;
            $display("FAIL reset_outputs: got ce=%b iv=%b res=%h flags=%h, want all zero",
                     alu_ce, alu_inp_valid, rsp_res, rsp_flags);
        end
        req0_valid = 1'b1;
        #1;
        checks++;
        if (req0_ready !== 1'b0) begin
            errors++;
            $display("FAIL reset_ready: got %b want 0", req0_ready);
        end
        req0_valid = 1'b0;
        @(negedge clk);
        reset = 1'b0;
    endtask

    task automatic test_single_add();
        int   t, ch;
        exp_t e;
        @(negedge clk);
        drive(0, 1'b1, 4'd0, 8'h0F, 8'h01, 1'b0);
        #1;
        t = cyc;
        checks++;
        if (req0_ready !== 1'b1 || req1_ready !== 1'b0) begin
            errors++;
            $display("FAIL add_ready: got r0=%b r1=%b want r0=1 r1=0", req0_ready, req1_ready);
        end
        @(negedge clk);
        req0_valid = 1'b0;
        checks++;
        if (alu_inp_valid !== 2'b11 || alu_ce !== 1'b1 || alu_opa !== 8'h0F) begin
            errors++;
            $display("FAIL add_issue: got iv=%b ce=%b opa=%h want 11 1 0f",
                     alu_inp_valid, alu_ce, alu_opa);
        end
        wait_rsp(10, ch);
        pop_exp(e);
        checks++;
        if (ch !== 0 || cyc !== t + 3) begin
            errors++;
            $display("FAIL add_timing: got ch=%0d cyc=%0d want ch=0 cyc=%0d", ch, cyc, t + 3);
        end
        checks++;
        if (rsp_res !== 10'h010 || rsp_flags[5] !== 1'b0) begin
            errors++;
            $display("FAIL add_result: got res=%h err=%b want 010 0", rsp_res, rsp_flags[5]);
        end
        checks++;
        if (e.ch !== 0 || e.res !== rsp_res || e.flags !== rsp_flags || e.due !== cyc) begin
            errors++;
            $display("FAIL add_scoreboard: got res=%h flags=%h want res=%h flags=%h due=%0d",
                     rsp_res, rsp_flags, e.res, e.flags, e.due);
        end
        @(negedge clk);
        checks++;
        if (rsp0_valid !== 1'b0 || rsp1_valid !== 1'b0) begin
            errors++;
            $display("FAIL add_pulse_width: got r0=%b r1=%b want 0 0", rsp0_valid, rsp1_valid);
        end
    endtask

    task automatic test_mul_latency();
        int   t, ch;
        exp_t e;
        @(negedge clk);
        drive(1, 1'b1, 4'd9, 8'd3, 8'd4, 1'b0);
        #1;
        t = cyc;
        @(negedge clk);
        req1_valid = 1'b0;
        checks++;
        if (rsp_res !== 10'h010) begin
            errors++;
            $display("FAIL mul_hold_prev: got res=%h want 010", rsp_res);
        end
        wait_rsp(10, ch);
        pop_exp(e);
        checks++;
        if (ch !== 1 || cyc !== t + 4) begin
            errors++;
            $display("FAIL mul_timing: got ch=%0d cyc=%0d want ch=1 cyc=%0d", ch, cyc, t + 4);
        end
        checks++;
        if (rsp_res !== 10'd20 || e.res !== rsp_res || e.due !== cyc) begin
            errors++;
            $display("FAIL mul_result: got res=%0d want 20 (sb res=%0d due=%0d)",
                     rsp_res, e.res, e.due);
        end
    endtask

    task automatic test_error_passthrough();
        int   ch;
        exp_t e;
        @(negedge clk);
        drive(0, 1'b1, 4'd14, 8'd5, 8'd7, 1'b0);
        @(negedge clk);
        req0_valid = 1'b0;
        checks++;
        if (alu_cmd !== 4'd14 || alu_mode !== 1'b1) begin
            errors++;
            $display("FAIL err_cmd_pass: got cmd=%0d mode=%b want 14 1", alu_cmd, alu_mode);
        end
        wait_rsp(10, ch);
        pop_exp(e);
        checks++;
        if (ch !== 0 || rsp_flags[5] !== 1'b1 || e.flags !== rsp_flags || e.due !== cyc) begin
            errors++;
            $display("FAIL err_flag: got ch=%0d flags=%b want ch=0 flags=%b", ch, rsp_flags,
                     e.flags);
        end
    endtask

    task automatic test_contention();
        int   ch, want_ch, lat0, lat1, prev, br0;
        exp_t e;
        @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        exp_q.delete();
        br0 = both_ready_cnt;
        rand_op(0, lat0);
        rand_op(1, lat1);
        prev = -1;
        for (int k = 0; k < 4; k++) begin
`ifdef ALU_ARB_FIXED_PRIO_EN
            want_ch = 0;
`else
            want_ch = k % 2;
`endif
            wait_rsp(12, ch);
            pop_exp(e);
            checks++;
            if (ch !== want_ch || e.ch !== want_ch || e.res !== rsp_res
                || e.flags !== rsp_flags || e.due !== cyc) begin
                errors++;
                $display("FAIL contend_op%0d: got ch=%0d res=%h flags=%h cyc=%0d want ch=%0d res=%h flags=%h cyc=%0d",
                         k, ch, rsp_res, rsp_flags, cyc, want_ch, e.res, e.flags, e.due);
            end
            if (prev >= 0) begin
                checks++;
                if (cyc - prev !== 2 + (want_ch == 1 ? lat1 : lat0)) begin
                    errors++;
                    $display("FAIL contend_gap%0d: got %0d want %0d", k, cyc - prev,
                             2 + (want_ch == 1 ? lat1 : lat0));
                end
            end
            prev = cyc;
            if (k == 3) begin
                req0_valid = 1'b0;
`ifndef ALU_ARB_FIXED_PRIO_EN
                req1_valid = 1'b0;
`endif
            end else begin
                rand_op(0, lat0);
                rand_op(1, lat1);
            end
        end
`ifdef ALU_ARB_FIXED_PRIO_EN
        wait_rsp(12, ch);
        req1_valid = 1'b0;
        pop_exp(e);
        checks++;
        if (ch !== 1 || e.ch !== 1 || e.res !== rsp_res || e.due !== cyc) begin
            errors++;
            $display("FAIL prio_req1_after_drop: got ch=%0d res=%h want ch=1 res=%h",
                     ch, rsp_res, e.res);
        end
`endif
        repeat (5) @(negedge clk);
        checks++;
        if (exp_q.size() !== 0 || both_ready_cnt !== br0) begin
            errors++;
            $display("FAIL contend_drain: got pending=%0d both_ready=%0d want 0 0",
                     exp_q.size(), both_ready_cnt - br0);
        end
    endtask

    task automatic test_reset_mid_wait();
        int   t, ch;
        exp_t e;
        @(negedge clk);
        drive(0, 1'b1, 4'd9, 8'd7, 8'd2, 1'b0);
        @(negedge clk);
        req0_valid = 1'b0;
        @(negedge clk);
        checks++;
        if (alu_ce !== 1'b1) begin
            errors++;
            $display("FAIL rst_wait_busy: got ce=%b want 1", alu_ce);
        end
        reset = 1'b1;
        #1;
        checks++;
        if ({req0_ready, req1_ready, rsp0_valid, rsp1_valid, alu_ce, alu_inp_valid, alu_mode,
             alu_cmd, alu_opa, alu_opb, alu_cin, rsp_res, rsp_flags} !== '0) begin
            errors++;
            $display("FAIL rst_wait_outputs: got ce=%b iv=%b opa=%h res=%h want all zero",
                     alu_ce, alu_inp_valid, alu_opa, rsp_res);
        end
        exp_q.delete();
        repeat (2) @(negedge clk);
        reset = 1'b0;
        wait_rsp(6, ch);
        checks++;
        if (ch !== -1) begin
            errors++;
            $display("FAIL rst_wait_no_rsp: got ch=%0d want none", ch);
        end
        @(negedge clk);
        drive(1, 1'b1, 4'd0, 8'h20, 8'h05, 1'b0);
        #1;
        t = cyc;
        @(negedge clk);
        req1_valid = 1'b0;
        wait_rsp(10, ch);
        pop_exp(e);
        checks++;
        if (ch !== 1 || cyc !== t + 3 || rsp_res !== 10'h025 || e.res !== rsp_res) begin
            errors++;
            $display("FAIL rst_wait_next_op: got ch=%0d cyc=%0d res=%h want ch=1 cyc=%0d res=025",
                     ch, cyc, rsp_res, t + 3);
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got no finish want finish before timeout");
        $fatal(1);
    end

    initial begin
        test_reset();
        test_single_add();
        test_mul_latency();
        test_error_passthrough();
        test_contention();
        test_reset_mid_wait();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/alu_req_arbiter.md
Name: alu_req_arbiter

Overview:
Shares one ALU instance between two independent requesters (req0, req1) with round-robin arbitration. Per operation it latches the winner's command and operands, drives the ALU input bus for the command's fixed latency, captures result and flags, and returns them on the winner's response channel. Sits between the requester blocks and the ALU; the only block allowed to drive ALU inputs.

Parameters:
N_WIDTH, 8, ALU operand width; result width is N_WIDTH+2
M_WIDTH, 4, ALU command width
LAT_NORM, 1, result latency in cycles after issue edge for all non-multiply commands
LAT_MUL, 2, result latency for multiply commands (mode=1, cmd 9 or 10)

Ports:
clk  in  1  clock, all logic on rising edge
reset  in  1  asynchronous active-high reset
reqX_valid  in  1  requester X (X=0,1) has an operation pending
reqX_ready  out  1  arbiter accepts requester X this cycle
reqX_mode  in  1  ALU mode (1 arithmetic, 0 logical)
reqX_cmd  in  M_WIDTH  ALU command
reqX_opa, reqX_opb  in  N_WIDTH  operands
reqX_cin  in  1  carry in
rspX_valid  out  1  one-cycle pulse: response for requester X
rsp_res  out  N_WIDTH+2  captured ALU result (shared by both channels)
rsp_flags  out  6  captured {err,oflow,cout,g,l,e}
alu_ce  out  1  ALU clock enable
alu_inp_valid  out  2  ALU operand valid
alu_mode, alu_cmd, alu_opa, alu_opb, alu_cin  out  as req  ALU command/operands
alu_res  in  N_WIDTH+2  ALU result
alu_err, alu_oflow, alu_cout, alu_g, alu_l, alu_e  in  1 each  ALU flags

Behaviour:
- Reset (async, immediate): state IDLE, last_grant=1 (req0 wins first), all outputs 0, latches cleared, any in-flight op dropped, no rsp pulse.
- FSM IDLE -> ISSUE -> WAIT -> CAPTURE -> IDLE.
- IDLE: grant = round-robin among valid requesters, favouring the one not equal to last_grant. reqX_ready = (state==IDLE) && grant==X (combinational); at most one ready high. Handshake = valid&&ready: latch mode/cmd/opa/opb/cin, record grant, update last_grant, go to ISSUE. No valid: stay IDLE.
- ISSUE (1 cycle): drive alu_* from latches, alu_ce=1, alu_inp_valid=2'b11; load cnt = LAT_MUL if mode==1 && cmd in {9,10} else LAT_NORM.
- WAIT: hold alu_* and ce/inp_valid stable; decrement cnt each cycle; at cnt==1 go to CAPTURE.
- CAPTURE: register alu_res and flags into rsp_res/rsp_flags; next cycle (back in IDLE) rspX_valid pulses for exactly one cycle for recorded grant only.
- Outside ISSUE/WAIT/CAPTURE: alu_ce=0, alu_inp_valid=2'b00, alu_* operands hold last values.
- Timing: handshake at cycle T -> rsp pulse at T+2+LAT. rsp_res/rsp_flags hold until next CAPTURE.
- New handshake allowed in the same IDLE cycle as the rsp pulse.
- Invalid commands (out-of-range cmd, ROR/ROL with large opb) passed through unchanged; ALU err reported in rsp_flags[5]; no arbiter-side filtering.
- reqX_valid dropping while not granted: no effect, no latched state.

Optional Feature:
ALU_ARB_FIXED_PRIO_EN: defined -> fixed priority, req0 always wins over req1 when both valid; last_grant unused. Undefined -> round-robin as above.

Test Plan:
- Single ADD: req0 mode=1 cmd=0 opa=8'h0F opb=8'h01 at T -> alu_inp_valid=11 at T+1, rsp0_valid at T+3, rsp_res=10'h010, err=0; rsp1_valid never high.
- Multiply latency: req1 mode=1 cmd=9 opa=3 opb=4 -> rsp1_valid exactly at T+4, rsp_res=20 (=(3+1)*(4+1)).
- Contention: req0 and req1 continuously valid after reset -> grants alternate 0,1,0,1; each response on the matching channel; never both ready.
- Reset mid-WAIT: assert reset during WAIT of a MUL op -> all outputs 0 immediately, no rsp pulse after release, next op completes normally.
- Error pass-through: req0 mode=1 cmd=14 -> rsp0_valid with rsp_flags[5]=1.
- With ALU_ARB_FIXED_PRIO_EN: both continuously valid -> req0 granted every op, req1 starves until req0_valid drops.
